instr_fetch: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter. Takes the current PC and issues a single-outstanding request to instruction memory using a req/gnt/rvalid handshake. Holds the returned word in the IF/ID pipeline register for decode. Drives `hold` back to the PC register so the PC advances only when a fetch is granted, and discards wrong-path fetches on a redirect.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_skid.sv | 59 +++++
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, the default
// bubble instruction and the response record used by the skid buffer and IF/ID.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FULL,
      DISCARD
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_resp_t;

endpackage

// File: rtl/fetch_skid.sv
// Skid buffer plus IF/ID pipeline register. Parks one response while decode
// is stalled and occupied, and presents NOP whenever IF/ID is empty.
module fetch_skid import fetch_pkg::*; #(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_flush,
   input  logic        i_stallID,
   input  logic        i_loadResp,
   input  logic        i_parkResp,
   input  logic        i_drainSkid,
   input  fetch_resp_t i_resp,
   output logic        o_idAccept,
   output logic        o_validID,
   output logic [31:0] o_instrID,
   output logic [31:0] o_pcID
);

   fetch_resp_t r_ifid;
   fetch_resp_t r_skid;
   logic        r_validID;
   fetch_resp_t w_loadData;
   logic        w_load;

   always_comb begin
      w_loadData = i_drainSkid ? r_skid : i_resp;
      w_load     = i_loadResp || i_drainSkid;
   end

   // A redirect empties IF/ID; a stall freezes it; otherwise it is consumed.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_ifid    <= '0;
         r_validID <= 1'b0;
      end else if (i_flush) begin
         r_validID <= 1'b0;
      end else if (w_load) begin
         r_ifid    <= w_loadData;
         r_validID <= 1'b1;
      end else if (!i_stallID) begin
         r_validID <= 1'b0;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_skid <= '0;
      end else if (i_parkResp) begin
         r_skid <= i_resp;
      end
   end

   assign o_idAccept = !r_validID || !i_stallID;
   assign o_validID  = r_validID;
   assign o_instrID  = r_validID ? r_ifid.instr : NOP_INSTR;
   assign o_pcID     = r_ifid.pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: single-outstanding req/gnt/rvalid fetch from PC,
// PC hold control, and wrong-path discard on redirect.
module instr_fetch import fetch_pkg::*; #(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] PC,
   input  logic        flush,
   input  logic        stallID,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemGnt,
   input  logic        imemRvalid,
   input  logic [31:0] imemRdata,
   output logic        hold,
   output logic        validID,
   output logic [31:0] instrID,
   output logic [31:0] pcID
);

   fetch_state_t r_state;
   fetch_state_t w_nextState;
   logic [31:0]  r_pcReq;
   logic         w_idAccept;
   logic         w_grant;
   logic         w_loadResp;
   logic         w_parkResp;
   logic         w_drainSkid;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Flush outranks every response; DISCARD leaves only once the stale word is gone.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_grant) w_nextState = WAIT;
         end
         WAIT: begin
            if (flush) begin
               w_nextState = imemRvalid ? IDLE : DISCARD;
            end else if (imemRvalid) begin
               w_nextState = w_idAccept ? IDLE : FULL;
            end
         end
         FULL: begin
            if (flush || w_idAccept) w_nextState = IDLE;
         end
         DISCARD: begin
            if (imemRvalid) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      imemReq     = (r_state == IDLE) && !flush && !Reset;
      imemAddr    = PC;
      w_grant     = imemReq && imemGnt;
      hold        = !w_grant;
      w_loadResp  = (r_state == WAIT) && imemRvalid && !flush && w_idAccept;
      w_parkResp  = (r_state == WAIT) && imemRvalid && !flush && !w_idAccept;
      w_drainSkid = (r_state == FULL) && !flush && w_idAccept;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_pcReq <= '0;
      end else if (w_grant) begin
         r_pcReq <= PC;
      end
   end

   fetch_skid #(
      .NOP_INSTR (NOP_INSTR)
   ) u_skid (
      .i_clock     (Clock),
      .i_reset     (Reset),
      .i_flush     (flush),
      .i_stallID   (stallID),
      .i_loadResp  (w_loadResp),
      .i_parkResp  (w_parkResp),
      .i_drainSkid (w_drainSkid),
      .i_resp      ('{instr: imemRdata, pc: r_pcReq}),
      .o_idAccept  (w_idAccept),
      .o_validID   (validID),
      .o_instrID   (instrID),
      .o_pcID      (pcID)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a PC/memory model issues fetches, the
// expected in-order instruction stream is queued, and a monitor checks decode.
module tb_instr_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] PC;
   logic        flush, stallID, imemReq, imemGnt, imemRvalid, hold, validID;
   logic [31:0] imemAddr, imemRdata, instrID, pcID;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t        expQ[$];
   int          assertCount = 0;
   int          failCount = 0;
   bit          memBusy, lastGrant, lastFlush;
   int          memCnt;
   logic [31:0] memWord;

   instr_fetch dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .PC         (PC),
      .flush      (flush),
      .stallID    (stallID),
      .imemReq    (imemReq),
      .imemAddr   (imemAddr),
      .imemGnt    (imemGnt),
      .imemRvalid (imemRvalid),
      .imemRdata  (imemRdata),
      .hold       (hold),
      .validID    (validID),
      .instrID    (instrID),
      .pcID       (pcID)
   );

   always #5 Clock = ~Clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // One clock cycle of PC register + memory behaviour; grants queue the expected word.
   task automatic applyStimulus(input bit f, input bit s, input bit g, input int lat, input logic [31:0] data);
      @(negedge Clock);
      if (lastFlush) PC = $urandom & 32'hFFFF_FFFC;
      else if (lastGrant) PC = PC + 32'd4;
      imemRvalid = 1'b0;
      imemRdata  = $urandom;
      if (memBusy) begin
         if (memCnt == 0) begin
            imemRvalid = 1'b1;
            imemRdata  = memWord;
            memBusy    = 1'b0;
         end else begin
            memCnt--;
         end
      end
      flush   = f;
      stallID = s;
      imemGnt = g;
      #1;
      checkOutput("addrIsPC", imemAddr, PC);
      checkOutput("holdRule", 32'(hold), 32'(!(imemReq && imemGnt)));
      if (imemReq) checkOutput("singleOutstanding", 32'(memBusy), 32'd0);
      lastGrant = imemReq && imemGnt;
      lastFlush = f;
      if (lastGrant) begin
         memBusy = 1'b1;
         memCnt  = lat - 1;
         memWord = data;
         expQ.push_back('{data, PC});
      end
   endtask

   // Decode consumes IF/ID whenever it is valid and not stalled; a flush kills everything younger.
   always @(negedge Clock) begin
      exp_t e;
      #2;
      if (!Reset) begin
         if (!validID) checkOutput("nopWhenEmpty", instrID, NOP);
         if (validID && !stallID) begin
            if (expQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpectedInstr: got %h pc %h, expected nothing at %0t", instrID, pcID, $time);
            end else begin
               e = expQ.pop_front();
               checkOutput("instrID", instrID, e.instr);
               checkOutput("pcID", pcID, e.pc);
            end
         end
         if (flush) expQ.delete();
      end
   end

   initial begin
      logic [31:0] savedAddr, aWord, pcA, pcB;
      int cycles;
      PC = '0; flush = 0; stallID = 0; imemGnt = 0; imemRvalid = 0; imemRdata = '0;
      memBusy = 0; memCnt = 0; memWord = '0; lastGrant = 0; lastFlush = 0;

      repeat (2) @(negedge Clock);
      #1;
      checkOutput("rstHold", 32'(hold), 32'd1);
      checkOutput("rstReq", 32'(imemReq), 32'd0);
      checkOutput("rstValid", 32'(validID), 32'd0);
      checkOutput("rstInstr", instrID, NOP);
      checkOutput("rstPc", pcID, 32'd0);
      @(posedge Clock);
      #2 Reset = 1'b0;

      applyStimulus(0, 0, 1, 1, 32'hDEADBEEF);
      checkOutput("firstReq", 32'(imemReq), 32'd1);
      checkOutput("firstAddr", imemAddr, 32'd0);
      applyStimulus(0, 0, 0, 1, 32'd0);
      applyStimulus(0, 0, 0, 1, 32'd0);
      checkOutput("firstValid", 32'(validID), 32'd1);
      checkOutput("firstInstr", instrID, 32'hDEADBEEF);
      checkOutput("firstPc", pcID, 32'd0);

      savedAddr = PC;
      repeat (3) begin
         applyStimulus(0, 0, 0, 1, 32'd0);
         checkOutput("noGntReq", 32'(imemReq), 32'd1);
         checkOutput("noGntAddr", imemAddr, savedAddr);
         checkOutput("noGntHold", 32'(hold), 32'd1);
      end

      aWord = $urandom;
      applyStimulus(0, 0, 1, 1, aWord);
      pcA = PC;
      applyStimulus(0, 0, 0, 1, 32'd0);
      applyStimulus(0, 1, 1, 2, 32'h00A00093);
      pcB = PC;
      applyStimulus(0, 1, 0, 1, 32'd0);
      applyStimulus(0, 1, 0, 1, 32'd0);
      applyStimulus(0, 1, 0, 1, 32'd0);
      checkOutput("fullNoReq", 32'(imemReq), 32'd0);
      checkOutput("fullValid", 32'(validID), 32'd1);
      checkOutput("fullInstr", instrID, aWord);
      checkOutput("fullPc", pcID, pcA);
      applyStimulus(0, 0, 0, 1, 32'd0);
      applyStimulus(0, 0, 0, 1, 32'd0);
      checkOutput("drainValid", 32'(validID), 32'd1);
      checkOutput("drainInstr", instrID, 32'h00A00093);
      checkOutput("drainPc", pcID, pcB);

      applyStimulus(0, 0, 1, 4, 32'h12345678);
      applyStimulus(1, 0, 0, 1, 32'd0);
      applyStimulus(0, 0, 1, 1, 32'd0);
      checkOutput("discardNoReq", 32'(imemReq), 32'd0);
      checkOutput("discardValid", 32'(validID), 32'd0);
      applyStimulus(0, 0, 1, 1, 32'd0);
      checkOutput("discardNoReq2", 32'(imemReq), 32'd0);
      applyStimulus(0, 0, 0, 1, 32'd0);
      checkOutput("discardDropReq", 32'(imemReq), 32'd0);
      applyStimulus(0, 0, 0, 1, 32'd0);
      checkOutput("afterDropReq", 32'(imemReq), 32'd1);
      checkOutput("afterDropValid", 32'(validID), 32'd0);

      applyStimulus(0, 0, 1, 1, $urandom);
      applyStimulus(1, 0, 0, 1, 32'd0);
      applyStimulus(0, 0, 0, 1, 32'd0);
      checkOutput("flushRvValid", 32'(validID), 32'd0);
      checkOutput("flushRvInstr", instrID, NOP);
      checkOutput("flushRvReq", 32'(imemReq), 32'd1);

      applyStimulus(0, 0, 1, 1, $urandom);
      applyStimulus(0, 0, 0, 1, 32'd0);
      applyStimulus(0, 1, 1, 1, $urandom);
      applyStimulus(0, 1, 0, 1, 32'd0);
      applyStimulus(1, 1, 0, 1, 32'd0);
      applyStimulus(0, 0, 0, 1, 32'd0);
      checkOutput("flushFullValid", 32'(validID), 32'd0);
      checkOutput("flushFullInstr", instrID, NOP);
      checkOutput("flushFullReq", 32'(imemReq), 32'd1);

      applyStimulus(0, 0, 1, 5, $urandom);
      applyStimulus(0, 0, 0, 1, 32'd0);
      #2 Reset = 1'b1;
      #1;
      checkOutput("asyncRstValid", 32'(validID), 32'd0);
      checkOutput("asyncRstPc", pcID, 32'd0);
      checkOutput("asyncRstReq", 32'(imemReq), 32'd0);
      checkOutput("asyncRstHold", 32'(hold), 32'd1);
      memBusy = 0; expQ.delete(); PC = '0; lastGrant = 0; lastFlush = 0;
      imemRvalid = 0; flush = 0; stallID = 0; imemGnt = 0;
      @(posedge Clock);
      #2 Reset = 1'b0;

      for (int i = 0; i < 2000; i++) begin
         applyStimulus($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30,
                       $urandom_range(0, 99) < 70, $urandom_range(1, 4), $urandom);
      end

      cycles = 0;
      while ((memBusy || expQ.size() != 0) && cycles < 100) begin
         applyStimulus(0, 0, 0, 1, 32'd0);
         cycles++;
      end
      applyStimulus(0, 0, 0, 1, 32'd0);
      checkOutput("drained", 32'(expQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
